// File: rtl/bp_be_dcache_reservation.sv
// rtl/bp_be_dcache_reservation.sv - LR/SC block reservation tracker with post-LR snoop hold window
// Optional failed-SC statistics counter enabled by BP_BE_DCACHE_RESV_STATS_EN.
module bp_be_dcache_reservation
  #(parameter int paddr_width_p        = 40
  , parameter int dcache_block_width_p = 512
  , parameter int lr_hold_p            = 64
  , localparam int blk_offset_lp       = $clog2(dcache_block_width_p/8)
  , localparam int tag_width_lp        = paddr_width_p - blk_offset_lp
  )
  (input  logic                     clk_i
  , input  logic                     reset_i
  , input  logic                     v_i
  , input  logic                     lr_i
  , input  logic                     sc_i
  , input  logic [paddr_width_p-1:0] paddr_i
  , input  logic                     flush_i
  , input  logic                     snoop_v_i
  , input  logic [paddr_width_p-1:0] snoop_paddr_i
  , output logic                     snoop_ready_o
  , output logic                     sc_v_o
  , output logic                     sc_success_o
  , output logic                     reserved_o
  , output logic [tag_width_lp-1:0]  resv_tag_o
  , output logic [15:0]              sc_fail_cnt_o
  );

  // A zero-length hold window never uses the counter; keep it one bit wide.
  localparam int cnt_width_lp = (lr_hold_p > 0) ? $clog2(lr_hold_p+1) : 1;

  typedef enum logic [1:0] {e_idle, e_hold, e_resv} state_e;

  state_e                  state_r, state_n;
  logic [cnt_width_lp-1:0] cnt_r, cnt_n;
  logic [tag_width_lp-1:0] tag_r, tag_n;
  logic                    sc_v_n, sc_success_n;

  wire [tag_width_lp-1:0] op_tag    = paddr_i[paddr_width_p-1:blk_offset_lp];
  wire [tag_width_lp-1:0] snoop_tag = snoop_paddr_i[paddr_width_p-1:blk_offset_lp];
  wire unused_offsets = ^{paddr_i[blk_offset_lp-1:0], snoop_paddr_i[blk_offset_lp-1:0]};

  assign snoop_ready_o = (state_r != e_hold);
  assign reserved_o    = (state_r != e_idle);
  assign resv_tag_o    = tag_r;

  wire snoop_hit = snoop_v_i & snoop_ready_o & (state_r == e_resv) & (snoop_tag == tag_r);

  always_comb begin
    state_n      = state_r;
    cnt_n        = cnt_r;
    tag_n        = tag_r;
    sc_v_n       = 1'b0;
    sc_success_n = 1'b0;
    if (flush_i) begin
      state_n = e_idle;
      cnt_n   = '0;
      sc_v_n  = v_i & sc_i;
    end else begin
      if (state_r == e_hold) begin
        cnt_n = cnt_r - cnt_width_lp'(1);
        if (cnt_n == '0)
          state_n = e_resv;
      end
      if (snoop_hit)
        state_n = e_idle;
      // An LR always (re)takes the reservation, even against a matching snoop.
      if (v_i & lr_i) begin
        tag_n = op_tag;
        if (lr_hold_p == 0) begin
          state_n = e_resv;
          cnt_n   = '0;
        end else begin
          state_n = e_hold;
          cnt_n   = cnt_width_lp'(lr_hold_p);
        end
      end else if (v_i & sc_i) begin
        sc_v_n       = 1'b1;
        sc_success_n = (state_r != e_idle) & ~snoop_hit & (op_tag == tag_r);
        state_n      = e_idle;
        cnt_n        = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r      <= e_idle;
      cnt_r        <= '0;
      tag_r        <= '0;
      sc_v_o       <= 1'b0;
      sc_success_o <= 1'b0;
    end else begin
      state_r      <= state_n;
      cnt_r        <= cnt_n;
      tag_r        <= tag_n;
      sc_v_o       <= sc_v_n;
      sc_success_o <= sc_success_n;
    end
  end

`ifdef BP_BE_DCACHE_RESV_STATS_EN
  logic [15:0] fail_cnt_r;
  always_ff @(posedge clk_i) begin
    if (reset_i)
      fail_cnt_r <= '0;
    else if (sc_v_o & ~sc_success_o & (fail_cnt_r != 16'hFFFF))
      fail_cnt_r <= fail_cnt_r + 16'd1;
  end
  assign sc_fail_cnt_o = fail_cnt_r;
`else
  assign sc_fail_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bp_be_dcache_reservation.sv
// tb/tb_bp_be_dcache_reservation.sv - directed self-checking bench for the LR/SC reservation tracker
module tb_bp_be_dcache_reservation;

  localparam int paddr_w = 40;
  localparam int tag_w   = 34;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               v = 1'b0, lr = 1'b0, sc = 1'b0, flush = 1'b0, snoop_v = 1'b0;
  logic [paddr_w-1:0] paddr = '0, snoop_paddr = '0;
  logic               snoop_ready, sc_v, sc_success, reserved;
  logic [tag_w-1:0]   resv_tag;
  logic [15:0]        sc_fail_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bp_be_dcache_reservation #(.paddr_width_p(paddr_w), .dcache_block_width_p(512), .lr_hold_p(4)) dut
    (.clk_i(clk), .reset_i(reset), .v_i(v), .lr_i(lr), .sc_i(sc), .paddr_i(paddr)
    ,.flush_i(flush), .snoop_v_i(snoop_v), .snoop_paddr_i(snoop_paddr)
    ,.snoop_ready_o(snoop_ready), .sc_v_o(sc_v), .sc_success_o(sc_success)
    ,.reserved_o(reserved), .resv_tag_o(resv_tag), .sc_fail_cnt_o(sc_fail_cnt));

  always @(posedge clk)
    if (v && lr && sc) $error("illegal lr+sc op driven");

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic l, input logic s, input logic [paddr_w-1:0] a);
    v = 1'b1; lr = l; sc = s; paddr = a;
    tick();
    v = 1'b0; lr = 1'b0; sc = 1'b0;
  endtask

  initial begin
    int exp_fail;
    tick(); tick();
    chk("rst_ready", snoop_ready, 1);
    chk("rst_sc_v", sc_v, 0);
    chk("rst_succ", sc_success, 0);
    chk("rst_resv", reserved, 0);
    chk("rst_tag", resv_tag, 0);
    chk("rst_cnt", sc_fail_cnt, 0);
    reset = 1'b0;
    tick();

    // LR then SC in the same block, issued three cycles later while still in hold
    op(1, 0, 40'h8000_0040);
    chk("t1_resv", reserved, 1);
    chk("t1_ready", snoop_ready, 0);
    chk("t1_tag", resv_tag, 34'h200_0001);
    tick(); tick();
    op(0, 1, 40'h8000_0078);
    chk("t1_sc_v", sc_v, 1);
    chk("t1_succ", sc_success, 1);
    chk("t1_resv_after", reserved, 0);
    tick();
    chk("t1_sc_v_pulse", sc_v, 0);

    // SC to a different block fails
    op(1, 0, 40'h8000_0040);
    op(0, 1, 40'h8000_0080);
    chk("t2_sc_v", sc_v, 1);
    chk("t2_succ", sc_success, 0);
    chk("t2_resv", reserved, 0);

    // Matching snoop is stalled for the hold window, then kills the reservation
    op(1, 0, 40'h1000);
    snoop_v = 1'b1; snoop_paddr = 40'h1000;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_hold_ready%0d", i), snoop_ready, 0);
      tick();
    end
    chk("t3_ready5", snoop_ready, 1);
    chk("t3_resv_pre", reserved, 1);
    tick();
    snoop_v = 1'b0;
    chk("t3_resv_post", reserved, 0);
    op(0, 1, 40'h1000);
    chk("t3_sc_v", sc_v, 1);
    chk("t3_succ", sc_success, 0);

    // Flush coincident with SC: SC reported as failed
    op(1, 0, 40'h1000);
    flush = 1'b1;
    op(0, 1, 40'h1000);
    flush = 1'b0;
    chk("t4_sc_v", sc_v, 1);
    chk("t4_succ", sc_success, 0);
    chk("t4_resv", reserved, 0);

    // Non-matching snoop in e_resv is accepted but harmless; plain load is ignored
    op(1, 0, 40'h1000);
    tick(); tick(); tick(); tick();
    chk("t5_ready", snoop_ready, 1);
    snoop_v = 1'b1; snoop_paddr = 40'h2000;
    tick();
    snoop_v = 1'b0;
    chk("t5_resv", reserved, 1);
    op(0, 0, 40'h3000);
    chk("t5_load_resv", reserved, 1);
    chk("t5_load_tag", resv_tag, 34'h40);
    op(0, 1, 40'h1000);
    chk("t5_sc_v", sc_v, 1);
    chk("t5_succ", sc_success, 1);

    // Matching snoop with SC in e_resv: SC fails
    op(1, 0, 40'h1000);
    tick(); tick(); tick(); tick();
    snoop_v = 1'b1; snoop_paddr = 40'h1010;
    op(0, 1, 40'h1000);
    snoop_v = 1'b0;
    chk("t6_sc_v", sc_v, 1);
    chk("t6_succ", sc_success, 0);
    chk("t6_resv", reserved, 0);

    // Matching snoop with LR in e_resv: LR wins, new tag, back to hold
    op(1, 0, 40'h1000);
    tick(); tick(); tick(); tick();
    snoop_v = 1'b1; snoop_paddr = 40'h1000;
    op(1, 0, 40'h5040);
    snoop_v = 1'b0;
    chk("t7_resv", reserved, 1);
    chk("t7_tag", resv_tag, 34'h141);
    chk("t7_ready", snoop_ready, 0);

    // Reset mid-hold, with an SC in flight: no pulse, everything back to reset values
    reset = 1'b1;
    op(0, 1, 40'h5040);
    chk("t8_sc_v", sc_v, 0);
    chk("t8_resv", reserved, 0);
    chk("t8_tag", resv_tag, 0);
    chk("t8_ready", snoop_ready, 1);
    reset = 1'b0;
    tick();

    // Three SCs with no reservation
    op(0, 1, 40'h1000);
    chk("t9_sc0_succ", sc_success, 0);
    op(0, 1, 40'h2000);
    op(0, 1, 40'h3000);
    chk("t9_sc2_v", sc_v, 1);
    tick(); tick();
`ifdef BP_BE_DCACHE_RESV_STATS_EN
    exp_fail = 3;
`else
    exp_fail = 0;
`endif
    chk("t9_fail_cnt", sc_fail_cnt, 64'(exp_fail));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
